// File: rtl/pll_pkg.sv
// Shared types and helpers for the DCO tuning-bank slewer.
// Width derivation and target clamping live here so sub-blocks agree.
package pll_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SLEW,
        DWELL
    } slew_state_t;

    function automatic int therm_bin_w(input int therm_bits);
        return $clog2(therm_bits + 1);
    endfunction

    function automatic int unsigned clamp_code(
        input int unsigned code,
        input int unsigned max_code
    );
        return (code > max_code) ? max_code : code;
    endfunction

endpackage

// File: rtl/bin_to_therm.sv
// Binary to thermometer encoder: code N sets bits [N-1:0].
// Purely combinational; registered by the caller.
module bin_to_therm
    import pll_pkg::*;
#(
    parameter int THERM_BITS = 255,
    localparam int BIN_W = therm_bin_w(THERM_BITS)
) (
    input  logic [BIN_W-1:0]      code,
    output logic [THERM_BITS-1:0] therm
);

    for (genvar i = 0; i < THERM_BITS; i++) begin : g_bit
        assign therm[i] = (BIN_W'(i) < code);
    end

endmodule

// File: rtl/dco_code_slewer.sv
// Walks the DCO thermometer bank toward a binary target in bounded,
// dwell-spaced steps so the oscillator never sees a large code jump.
module dco_code_slewer
    import pll_pkg::*;
#(
    parameter int THERM_BITS  = 255,
    parameter int BIN_W       = therm_bin_w(THERM_BITS),
    parameter int MAX_STEP    = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int RESET_CODE  = 127
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  target_valid,
    input  logic [BIN_W-1:0]      target_code,
    output logic                  target_ready,
    input  logic                  hold,
    output logic [THERM_BITS-1:0] therm_out,
    output logic [BIN_W-1:0]      current_code,
    output logic                  busy,
    output logic                  settled
);

    localparam int DW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [BIN_W-1:0] RST_CODE = BIN_W'(RESET_CODE);
    localparam logic [THERM_BITS:0] RST_ONEHOT =
        (THERM_BITS + 1)'(1) << RESET_CODE;
    localparam logic [THERM_BITS-1:0] RST_THERM =
        THERM_BITS'(RST_ONEHOT - 1'b1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(HOLD_CYCLES);
    localparam logic [BIN_W:0] STEP_CAP = (BIN_W + 1)'(MAX_STEP);

    slew_state_t            state_q, state_d;
    logic [BIN_W-1:0]       cur_q, cur_d;
    logic [BIN_W-1:0]       tgt_q, tgt_d;
    logic [DW-1:0]          dwell_q, dwell_d;
    logic                   settled_q, settled_d;
    logic [THERM_BITS-1:0]  therm_q, therm_d;

    logic [BIN_W-1:0]       tgt_clamped;
    logic signed [BIN_W:0]  diff;
    logic [BIN_W:0]         mag;
    logic [BIN_W:0]         step;
    logic [BIN_W-1:0]       stepped;

    assign tgt_clamped = BIN_W'(clamp_code(32'(target_code),
                                           32'(THERM_BITS)));

    // Signed difference one bit wider than the code so both directions fit.
    assign diff = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
    assign mag  = diff[BIN_W] ? unsigned'(-diff) : unsigned'(diff);
    assign step = (32'(mag) > 32'(MAX_STEP)) ? STEP_CAP : mag;
    assign stepped = diff[BIN_W] ? cur_q - step[BIN_W-1:0]
                                 : cur_q + step[BIN_W-1:0];

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        dwell_d   = dwell_q;
        settled_d = 1'b0;
        tgt_d     = target_valid ? tgt_clamped : tgt_q;
        unique case (state_q)
            IDLE: begin
                if (target_valid) begin
                    if (tgt_clamped == cur_q) settled_d = 1'b1;
                    else                      state_d   = SLEW;
                end
            end
            SLEW: begin
                if (!hold) begin
                    cur_d = stepped;
                    if (stepped == tgt_q) settled_d = 1'b1;
                    // A target arriving on the final step keeps us moving
                    // without breaking the inter-step dwell.
                    if (stepped == tgt_q &&
                        !(target_valid && tgt_clamped != stepped)) begin
                        state_d = IDLE;
                    end else if (HOLD_CYCLES > 0) begin
                        dwell_d = DWELL_LOAD;
                        state_d = DWELL;
                    end else begin
                        state_d = SLEW;
                    end
                end
            end
            DWELL: begin
                if (!hold) begin
                    dwell_d = dwell_q - DW'(1);
                    if (dwell_q == DW'(1)) state_d = SLEW;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    bin_to_therm #(
        .THERM_BITS(THERM_BITS)
    ) u_enc (
        .code (cur_d),
        .therm(therm_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_q     <= RST_CODE;
            tgt_q     <= RST_CODE;
            dwell_q   <= '0;
            settled_q <= 1'b0;
            therm_q   <= RST_THERM;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            dwell_q   <= dwell_d;
            settled_q <= settled_d;
            therm_q   <= therm_d;
        end
    end

    assign target_ready = ~rst;
    assign therm_out    = therm_q;
    assign current_code = cur_q;
    assign busy         = (tgt_q != cur_q);
    assign settled      = settled_q;

endmodule

// File: doc/dco_code_slewer.md
Name: dco_code_slewer

Overview:
- Drives the DCO thermometer-coded tuning bank from a binary target code.
- Does not jump to the target. It walks the registered thermometer output toward the target in bounded steps, with a programmable dwell between steps, so the oscillator never sees a large or glitchy capacitor-bank change.
- Sits between the loop filter / digital controller (binary side) and the DCO bank (thermometer side).
- Its thermometer encoding matches the thermometer-to-binary decoder's input convention: code N means bits [N-1:0] set.

Parameters:
- THERM_BITS, 255, width of the thermometer output.
- BIN_W, $clog2(THERM_BITS+1), binary code width (derived; do not override).
- MAX_STEP, 4, maximum change in code per step (≥1).
- HOLD_CYCLES, 2, idle clocks between consecutive steps (≥0).
- RESET_CODE, 127, code loaded at reset (≤THERM_BITS).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- target_valid  input  1  a new target code is offered.
- target_code  input  BIN_W  requested code; values >THERM_BITS are clamped to THERM_BITS.
- target_ready  output  1  always 1 out of reset; a target is accepted on any edge with target_valid=1.
- hold  input  1  freezes stepping and the dwell counter while high.
- therm_out  output  THERM_BITS  registered thermometer code; bits [current_code-1:0]=1, all others 0.
- current_code  output  BIN_W  registered binary equivalent of therm_out.
- busy  output  1  high while target_q != current_code (decoded from registers).
- settled  output  1  one-cycle registered pulse when an accepted target is reached.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - current_code=RESET_CODE; target_q=RESET_CODE; therm_out=encode(RESET_CODE).
  - dwell_cnt=0; state=IDLE; busy=0; settled=0; target_ready=0 during reset.
- Registers: target_q, current_code, therm_out (always updated at the same edge as current_code), dwell_cnt, state, settled.
- Acceptance:
  - On an edge with target_valid=1, target_q <= clamp(target_code).
  - A step on that same edge uses the old target_q; the new target takes effect from the next edge.
- States:
  - IDLE: target_q==current_code. On accept with a different code -> SLEW. On accept with an equal code -> settled pulses next cycle, stay IDLE.
  - SLEW: at each edge with hold=0, current_code moves toward target_q by min(MAX_STEP, |diff|).
    - If the new code == target_q: set settled and go to IDLE.
    - Else if HOLD_CYCLES>0: dwell_cnt<=HOLD_CYCLES, go to DWELL.
    - Else: stay in SLEW.
  - DWELL: dwell_cnt decrements each edge with hold=0; at 1 -> SLEW. Retarget in DWELL does not shorten the dwell.
- Timing:
  - Target accepted at edge E0 (state IDLE) -> first step at E1.
  - Subsequent steps at E1+k*(HOLD_CYCLES+1).
  - settled is high in the cycle after the final step edge; busy falls at that same edge.
- Retarget mid-slew: direction is recomputed from the new target_q; overshoot is impossible because each step is bounded by |diff|.
- hold=1: no code change and no dwell decrement. Acceptance still works.
- Invariants:
  - |Δcurrent_code| ≤ MAX_STEP per edge.
  - Steps are spaced ≥ HOLD_CYCLES+1 edges.
  - therm_out has no bubbles and always equals encode(current_code).
- Arithmetic:
  - The difference is computed at BIN_W+1 bits, signed.
  - The clamp compares at BIN_W+1 bits. It matters only when THERM_BITS+1 is not a power of two.
- Reset mid-slew: returns to RESET_CODE immediately (asynchronously); any pending target is discarded.

Decomposition:
- pll_pkg holds:
  - function therm_bin_w(THERM_BITS);
  - function clamp_code;
  - state enum slew_state_t {IDLE, SLEW, DWELL}.
- Sub-module bin_to_therm (parameter THERM_BITS): purely combinational, bit i = (i < code). Instanced once, feeding the therm_out register.
- Counter, FSM and handshake live in dco_code_slewer.

Test Plan (defaults unless stated):
1. Reset, then release -> current_code=127; therm_out[126:0] all 1 and [254:127] all 0; busy=0; settled=0.
2. Target 137 at E0 -> current_code 131@E1, 135@E4, 137@E7; settled=1 for exactly the cycle after E7; busy 1→0 at E7.
3. Target 120 at E0 -> 123@E1, 120@E4; therm_out[119:0]=1 and bit 120=0 after E4. Then target 120 again -> no steps; settled pulses once.
4. Target 0, then target 140 two cycles after E1 -> 123@E1, then 127@E4, continuing up to 140. No step ever exceeds 4; no step lands earlier than 3 edges after the previous one.
5. Target 200, hold=1 for 10 cycles after E1 -> current_code stays 131 while hold is high. Next step 3 edges after hold falls; no dwell cycles are lost.
6. THERM_BITS=10, RESET_CODE=0, MAX_STEP=16, HOLD_CYCLES=0: target 15 -> clamps to 10; current_code=10@E1; therm_out=10'h3FF. Then assert rst mid-slew -> outputs immediately return to 0.
